// File: rtl/alphamission_back1_mixer.sv
// Back1 / sprite / fix-layer colour mixer with CPU-writable 512x12 palette.
// Four-stage pixel pipeline advanced by the CK1 pixel enable:
//   S1 input capture -> S2 priority select -> S3 palette read -> S4 blank-gated output.
// The CPU reaches the palette as bytes: the even (RG) byte is held in a one-entry
// latch and committed together with the odd (B) byte. An odd byte arriving without a
// held even byte updates B only, keeping the entry's RG through a 2-clk read-modify-write.
module alphamission_back1_mixer #(
  parameter int         PAL_AW     = 9,
  parameter logic [3:0] TRANSP_COL = 4'd0
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       CK1,
  input  logic [3:0] B1D,
  input  logic [2:0] B1_BANK,
  input  logic [7:0] SPR_D,
  input  logic [3:0] FIX_D,
  input  logic [2:0] FIX_BANK,
  input  logic       HBLANKn,
  input  logic       VBLANKn,
  input  logic       PAL_CSn,
  input  logic       VWE,
  input  logic       VRD,
  input  logic [9:0] VA,
  input  logic [7:0] VD_in,
  output logic [7:0] VD_out,
  output logic [3:0] R,
  output logic [3:0] G,
  output logic [3:0] B,
  output logic [1:0] LAYER
);

  // Layer codes double as the top two bits of the palette index.
  localparam logic [1:0] LAYER_B1  = 2'b00;
  localparam logic [1:0] LAYER_SPR = 2'b01;
  localparam logic [1:0] LAYER_FIX = 2'b10;

  // CPU write sequencer states.
  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_RMW  = 2'd1;

  localparam int PAL_DEPTH = 1 << PAL_AW;

  // ------------------------------------------------------------------
  // Palette storage (not reset: contents survive RESET)
  // ------------------------------------------------------------------
  logic [11:0]       pal_mem [0:PAL_DEPTH-1];
  logic              mem_we;
  logic [PAL_AW-1:0] mem_waddr;
  logic [11:0]       mem_wdata;

  // ------------------------------------------------------------------
  // S1: input capture
  // ------------------------------------------------------------------
  logic [3:0] b1d_q;
  logic [2:0] b1_bank_q;
  logic [7:0] spr_q;
  logic [3:0] fix_q;
  logic [2:0] fix_bank_q;
  logic       blank1_q;

  // Sample all layer inputs and the combined blank flag on each pixel enable.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      b1d_q      <= 4'h0;
      b1_bank_q  <= 3'h0;
      spr_q      <= 8'h00;
      fix_q      <= 4'h0;
      fix_bank_q <= 3'h0;
      blank1_q   <= 1'b0;
    end else if (CK1) begin
      b1d_q      <= B1D;
      b1_bank_q  <= B1_BANK;
      spr_q      <= SPR_D;
      fix_q      <= FIX_D;
      fix_bank_q <= FIX_BANK;
      blank1_q   <= ~(HBLANKn & VBLANKn);
    end
  end

  // ------------------------------------------------------------------
  // S2: priority select and palette index formation
  // ------------------------------------------------------------------
  logic       spr_op;
  logic       fix_op;
  logic [1:0] layer_d;
  logic [2:0] bank_d;
  logic [3:0] colour_d;

  // Sprite with its priority bit beats fix; fix beats a normal sprite; Back1 is the backdrop.
  always_comb begin
    spr_op   = (spr_q[3:0] != TRANSP_COL);
    fix_op   = (fix_q != TRANSP_COL);
    layer_d  = LAYER_B1;
    bank_d   = b1_bank_q;
    colour_d = b1d_q;
    if (spr_op && spr_q[7]) begin
      layer_d  = LAYER_SPR;
      bank_d   = spr_q[6:4];
      colour_d = spr_q[3:0];
    end else if (fix_op) begin
      layer_d  = LAYER_FIX;
      bank_d   = fix_bank_q;
      colour_d = fix_q;
    end else if (spr_op) begin
      layer_d  = LAYER_SPR;
      bank_d   = spr_q[6:4];
      colour_d = spr_q[3:0];
    end
  end

  logic [PAL_AW-1:0] index2_q;
  logic [1:0]        layer2_q;
  logic              blank2_q;

  // Register the winning layer, its palette index and the blank flag.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      index2_q <= '0;
      layer2_q <= LAYER_B1;
      blank2_q <= 1'b0;
    end else if (CK1) begin
      index2_q <= {layer_d, bank_d, colour_d};
      layer2_q <= layer_d;
      blank2_q <= blank1_q;
    end
  end

  // ------------------------------------------------------------------
  // S3: synchronous palette read (old data on same-clk collision)
  // ------------------------------------------------------------------
  logic [11:0] pal_rd_q;
  logic [1:0]  layer3_q;
  logic        blank3_q;

  // Video read port; layer and blank travel alongside the read data.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      pal_rd_q <= 12'h000;
      layer3_q <= LAYER_B1;
      blank3_q <= 1'b0;
    end else if (CK1) begin
      pal_rd_q <= pal_mem[index2_q];
      layer3_q <= layer2_q;
      blank3_q <= blank2_q;
    end
  end

  // ------------------------------------------------------------------
  // S4: blank-gated output register
  // ------------------------------------------------------------------
  logic [11:0] rgb_q;
  logic [1:0]  layer_q;

  // Blanking forces black but the layer code is passed through untouched.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rgb_q   <= 12'h000;
      layer_q <= LAYER_B1;
    end else if (CK1) begin
      rgb_q   <= blank3_q ? 12'h000 : pal_rd_q;
      layer_q <= layer3_q;
    end
  end

  assign R     = rgb_q[11:8];
  assign G     = rgb_q[7:4];
  assign B     = rgb_q[3:0];
  assign LAYER = layer_q;

  // ------------------------------------------------------------------
  // CPU write path
  // ------------------------------------------------------------------
  logic              vwe_prev_q;
  logic              wr_strobe;
  logic [1:0]        wr_state_q, wr_state_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [PAL_AW-1:0] rmw_addr_q, rmw_addr_d;
  logic [3:0]        rmw_b_q, rmw_b_d;
  logic [7:0]        rmw_rg_q;

  // One commit per falling edge of VWE, however long the strobe is held.
  assign wr_strobe = ~PAL_CSn & vwe_prev_q & ~VWE;

  // Write sequencer: even byte -> hold latch, odd byte -> entry write (direct or RMW).
  always_comb begin
    wr_state_d   = wr_state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rmw_addr_d   = rmw_addr_q;
    rmw_b_d      = rmw_b_q;
    mem_we       = 1'b0;
    mem_waddr    = VA[9:1];
    mem_wdata    = {hold_q, VD_in[3:0]};
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_strobe) begin
          if (!VA[0]) begin
            hold_d       = VD_in;
            hold_valid_d = 1'b1;
          end else if (hold_valid_q) begin
            mem_we       = 1'b1;
            hold_valid_d = 1'b0;
          end else begin
            // RG is fetched this clk into rmw_rg_q and merged on the next one.
            rmw_addr_d = VA[9:1];
            rmw_b_d    = VD_in[3:0];
            wr_state_d = WR_RMW;
          end
        end
      end
      WR_RMW: begin
        mem_we     = 1'b1;
        mem_waddr  = rmw_addr_q;
        mem_wdata  = {rmw_rg_q, rmw_b_q};
        wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Sequencer state; reset drops the held byte and any half-done RMW.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      vwe_prev_q   <= 1'b0;
      wr_state_q   <= WR_IDLE;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      rmw_addr_q   <= '0;
      rmw_b_q      <= 4'h0;
    end else begin
      vwe_prev_q   <= VWE;
      wr_state_q   <= wr_state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_b_q      <= rmw_b_d;
    end
  end

  // RMW fetch of the existing RG nibbles, taken while the sequencer is idle.
  always_ff @(posedge clk) begin
    if (wr_state_q == WR_IDLE) begin
      rmw_rg_q <= pal_mem[VA[9:1]][11:4];
    end
  end

  // Single palette write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      pal_mem[mem_waddr] <= mem_wdata;
    end
  end

  // ------------------------------------------------------------------
  // CPU read path
  // ------------------------------------------------------------------
  logic        cpu_act_q;
  logic        cpu_bsel_q;
  logic [11:0] cpu_word_q;

  // Track whether last clk was a selected read cycle and which byte it wanted.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      cpu_act_q  <= 1'b0;
      cpu_bsel_q <= 1'b0;
    end else begin
      cpu_act_q  <= ~PAL_CSn & VRD;
      cpu_bsel_q <= VA[0];
    end
  end

  // CPU read port of the palette.
  always_ff @(posedge clk) begin
    cpu_word_q <= pal_mem[VA[9:1]];
  end

  // Byte select from the registered word; bus floats high when not selected.
  always_comb begin
    VD_out = 8'hFF;
    if (cpu_act_q) begin
      VD_out = cpu_bsel_q ? {4'h0, cpu_word_q[3:0]} : cpu_word_q[11:4];
    end
  end

endmodule
